// File: rtl/risc_core_p.sv
// risc_core_p: parametrised multi-cycle accumulator core.
//
// Instruction word is {opcode[2:0], ir_addr[ADDR_W-1:0]}, 2*DATA_W bits wide.
// It is stored as two memory words: the high beat at pc, the low beat at pc+1.
// The bus is a req/ready wait-state interface with separate read and write data.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   mem_ready   current access completes this cycle
//   mem_rdata   read data (valid with mem_ready during a read)
//   resume      leave the HALTED state
//   mem_rd/wr   read / write request (never both high)
//   mem_addr    access address (pc during fetch, ir_addr for data accesses)
//   mem_wdata   write data, always equal to acc
//   halt        core is halted
//   fetch       instruction fetch in progress
//   opcode      opcode field of ir
//   ir_addr     operand address field of ir
//   pc_addr     program counter
//   acc         accumulator
//   zero        acc == 0
module risc_core_p #(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned RESET_PC = 0,
  localparam int unsigned ADDR_W   = 2 * DATA_W - 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              resume,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halt,
  output logic              fetch,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [DATA_W-1:0] acc,
  output logic              zero
);

  localparam int unsigned IR_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_HI,
    S_F_LO,
    S_EXEC,
    S_M_RD,
    S_M_WR,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  op_t               op;

  assign op        = op_t'(ir_q[IR_W-1 -: 3]);
  assign opcode    = ir_q[IR_W-1 -: 3];
  assign ir_addr   = ir_q[ADDR_W-1:0];
  assign pc_addr   = pc_q;
  assign acc       = acc_q;
  assign mem_wdata = acc_q;
  assign zero      = (acc_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_A;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  // Bus outputs depend on state_q only, so mem_ready never reaches them
  // combinationally; mem_ready only gates the register updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = pc_q;
    halt     = 1'b0;
    fetch    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_F_HI;

      S_F_HI: begin
        mem_rd = 1'b1;
        fetch  = 1'b1;
        if (mem_ready) begin
          ir_d[IR_W-1:DATA_W] = mem_rdata;
          pc_d                = pc_q + ADDR_W'(1);
          state_d             = S_F_LO;
        end
      end

      S_F_LO: begin
        mem_rd = 1'b1;
        fetch  = 1'b1;
        if (mem_ready) begin
          ir_d[DATA_W-1:0] = mem_rdata;
          pc_d             = pc_q + ADDR_W'(1);
          state_d          = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_HLT: state_d = S_HALTED;
          OP_SKZ: begin
            if (zero) pc_d = pc_q + ADDR_W'(2);
            state_d = S_F_HI;
          end
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_F_HI;
          end
          OP_STO: state_d = S_M_WR;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = S_M_RD;
        endcase
      end

      S_M_RD: begin
        mem_rd   = 1'b1;
        mem_addr = ir_addr;
        if (mem_ready) begin
          case (op)
            OP_ADD:  acc_d = acc_q + mem_rdata;
            OP_AND:  acc_d = acc_q & mem_rdata;
            OP_XOR:  acc_d = acc_q ^ mem_rdata;
            default: acc_d = mem_rdata;
          endcase
          state_d = S_F_HI;
        end
      end

      S_M_WR: begin
        mem_wr   = 1'b1;
        mem_addr = ir_addr;
        if (mem_ready) state_d = S_F_HI;
      end

      S_HALTED: begin
        halt = 1'b1;
        if (resume) state_d = S_F_HI;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
